// File: rtl/qpsk_frame_receiver.sv
// rtl/qpsk_frame_receiver.sv - QPSK pilot-header hunter, hard slicer and frame packer
// Locks on a tolerant pilot header, then packs sliced data symbols into back-to-back frames.
module qpsk_frame_receiver #(
  parameter int HDR_LEN    = 5,
  parameter int HDR_MIN    = 4,
  parameter int FRAME_SYMS = 16,
  parameter int ERASE_TH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sym_en,
  input  logic                    relock,
  input  logic [3:0]              I_in,
  input  logic [3:0]              Q_in,
  output logic                    locked,
  output logic [2*FRAME_SYMS-1:0] frame_data,
  output logic                    frame_valid,
  output logic [6:0]              frame_erasures,
  output logic [7:0]              frame_cnt
);

  localparam int FW = 2 * FRAME_SYMS;

  typedef enum logic [1:0] {HUNT, HEADER, DATA} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    hdr_idx;
  logic [3:0]    match_cnt;
  logic [5:0]    sym_cnt;
  logic [6:0]    era_acc;
  logic [FW-1:0] shift_reg;

  logic          i_bit;
  logic          q_bit;
  logic          pilot;
  logic [3:0]    i_mag;
  logic [3:0]    q_mag;
  logic          i_erased;
  logic          q_erased;
  logic [1:0]    sym_erasures;
  logic [3:0]    match_total;
  logic          frame_last;
  logic [FW-1:0] shift_next;

  assign i_bit = ~I_in[3];
  assign q_bit = ~Q_in[3];
  assign pilot = i_bit & ~q_bit;

  // Magnitude kept as 4-bit unsigned so that -8 maps to 8 rather than wrapping.
  assign i_mag        = I_in[3] ? (~I_in + 4'd1) : I_in;
  assign q_mag        = Q_in[3] ? (~Q_in + 4'd1) : Q_in;
  assign i_erased     = (int'(i_mag) < ERASE_TH);
  assign q_erased     = (int'(q_mag) < ERASE_TH);
  assign sym_erasures = {1'b0, i_erased} + {1'b0, q_erased};

  assign match_total = match_cnt + {3'b000, pilot};
  assign frame_last  = (sym_cnt == 6'(FRAME_SYMS - 1));
  assign shift_next  = (shift_reg << 2) | FW'({i_bit, q_bit});
  assign locked      = (state == DATA);

  always_comb begin
    state_next = state;
    if (relock) begin
      state_next = HUNT;
    end else if (sym_en) begin
      case (state)
        HUNT:    if (pilot) state_next = (HDR_LEN == 1) ? DATA : HEADER;
        HEADER:  if (hdr_idx == 4'(HDR_LEN - 1))
                   state_next = (int'(match_total) >= HDR_MIN) ? DATA : HUNT;
        DATA:    state_next = DATA;
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hdr_idx        <= '0;
      match_cnt      <= '0;
      sym_cnt        <= '0;
      era_acc        <= '0;
      shift_reg      <= '0;
      frame_data     <= '0;
      frame_valid    <= 1'b0;
      frame_erasures <= '0;
      frame_cnt      <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (relock) begin
        hdr_idx   <= '0;
        match_cnt <= '0;
        sym_cnt   <= '0;
        era_acc   <= '0;
        shift_reg <= '0;
      end else if (sym_en) begin
        case (state)
          HUNT: begin
            hdr_idx   <= 4'd1;
            match_cnt <= 4'd1;
          end
          HEADER: begin
            hdr_idx   <= hdr_idx + 4'd1;
            match_cnt <= match_total;
          end
          DATA: begin
            if (frame_last) begin
              frame_data     <= shift_next;
              frame_erasures <= era_acc + {5'b0, sym_erasures};
              frame_valid    <= 1'b1;
              frame_cnt      <= frame_cnt + 8'd1;
              sym_cnt        <= '0;
              era_acc        <= '0;
              shift_reg      <= '0;
            end else begin
              sym_cnt   <= sym_cnt + 6'd1;
              era_acc   <= era_acc + {5'b0, sym_erasures};
              shift_reg <= shift_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpsk_frame_receiver.sv
// tb/tb_qpsk_frame_receiver.sv - self-checking bench for qpsk_frame_receiver
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_qpsk_frame_receiver;

  localparam int FS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sym_en = 1'b0;
  logic        relock = 1'b0;
  logic [3:0]  I_in = 4'd0;
  logic [3:0]  Q_in = 4'd0;
  logic        locked;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic [6:0]  frame_erasures;
  logic [7:0]  frame_cnt;

  qpsk_frame_receiver dut (
    .clk(clk), .reset(reset), .sym_en(sym_en), .relock(relock),
    .I_in(I_in), .Q_in(Q_in), .locked(locked), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_erasures(frame_erasures), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  bit          m_locked;
  int          hdr_q[$];
  int          fi[$];
  int          fq[$];
  logic [31:0] m_data;
  int          m_eras;
  int          m_cnt;
  bit          m_valid;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  bit chk_on = 1'b0;

  function automatic int mag(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_step(bit rst, bit en, bit rl, int i, int q);
    bit match;
    int sum;
    m_valid = 1'b0;
    if (!rst) begin
      m_locked = 1'b0; hdr_q.delete(); fi.delete(); fq.delete();
      m_data = '0; m_eras = 0; m_cnt = 0;
    end else if (rl) begin
      m_locked = 1'b0; hdr_q.delete(); fi.delete(); fq.delete();
    end else if (en) begin
      if (!m_locked) begin
        match = (i >= 0) && (q < 0);
        if (hdr_q.size() != 0 || match) hdr_q.push_back(int'(match));
        if (hdr_q.size() == 5) begin
          sum = 0;
          foreach (hdr_q[k]) sum += hdr_q[k];
          m_locked = (sum >= 4);
          hdr_q.delete();
        end
      end else begin
        fi.push_back(i);
        fq.push_back(q);
        if (fi.size() == FS) begin
          m_data = '0;
          m_eras = 0;
          for (int k = 0; k < FS; k++) begin
            m_data = {m_data[29:0], (fi[k] >= 0), (fq[k] >= 0)};
            m_eras += int'(mag(fi[k]) < 2) + int'(mag(fq[k]) < 2);
          end
          m_valid = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
          fi.delete();
          fq.delete();
        end
      end
    end
  endtask

  task automatic step(bit rst, bit en, bit rl, int i, int q);
    reset = rst; sym_en = en; relock = rl;
    I_in = 4'(i); Q_in = 4'(q);
    @(posedge clk);
    model_step(rst, en, rl, i, q);
    #1;
  endtask

  task automatic sym(int i, int q);
    step(1'b1, 1'b1, 1'b0, i, q);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pilots(int n);
    for (int k = 0; k < n; k++) sym(4, -4);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (locked !== m_locked || frame_valid !== m_valid || frame_data !== m_data ||
          frame_erasures !== 7'(m_eras) || frame_cnt !== 8'(m_cnt)) begin
        miscompares++;
        $display("FAIL cycle t=%0t: locked %b/%b valid %b/%b data %h/%h eras %0d/%0d cnt %0d/%0d (got/expected)",
                 $time, locked, m_locked, frame_valid, m_valid, frame_data, m_data,
                 frame_erasures, m_eras, frame_cnt, m_cnt);
      end
      if (frame_valid === 1'b1) pulses++;
    end
  end

  initial begin
    int p0;
    int ri;
    int rq;
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 4, -4);
    chk_on = 1'b1;
    check("reset locked", 32'(locked), 32'd0);
    check("reset data", frame_data, 32'd0);
    check("reset cnt", 32'(frame_cnt), 32'd0);
    check("reset eras", 32'(frame_erasures), 32'd0);

    pilots(4);
    check("t1 locked after 4", 32'(locked), 32'd0);
    pilots(1);
    check("t1 locked after 5", 32'(locked), 32'd1);
    check("t1 valid", 32'(frame_valid), 32'd0);

    step(1'b0, 1'b0, 1'b0, 0, 0);
    sym(4, -4); sym(-4, -4); pilots(3);
    check("t2 one bad locks", 32'(locked), 32'd1);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    sym(4, -4); sym(-4, -4); sym(4, 4); pilots(2);
    check("t2 two bad hunt", 32'(locked), 32'd0);
    check("t2 model hunt", 32'(m_locked), 32'd0);
    pilots(5);
    check("t2 relock ok", 32'(locked), 32'd1);

    for (int k = 0; k < 15; k++) if (k % 2 == 0) sym(5, -3); else sym(-5, 3);
    check("t3 no early valid", 32'(frame_valid), 32'd0);
    sym(-5, 3);
    check("t3 data", frame_data, 32'h9999_9999);
    check("t3 model data", m_data, 32'h9999_9999);
    check("t3 eras", 32'(frame_erasures), 32'd0);
    check("t3 valid", 32'(frame_valid), 32'd1);
    check("t3 cnt", 32'(frame_cnt), 32'd1);
    idle();
    check("t3 valid drop", 32'(frame_valid), 32'd0);

    for (int k = 0; k < 12; k++) sym(5, -3);
    for (int k = 0; k < 3; k++) sym(1, -1);
    sym(-8, 0);
    check("t4 eras", 32'(frame_erasures), 32'd7);
    check("t4 model eras", 32'(m_eras), 32'd7);
    check("t4 data", frame_data, 32'hAAAA_AAA9);
    check("t4 cnt", 32'(frame_cnt), 32'd2);

    for (int k = 0; k < 5; k++) sym(5, -3);
    idle(); idle(); idle();
    check("t5 idle locked", 32'(locked), 32'd1);
    check("t5 idle data", frame_data, 32'hAAAA_AAA9);
    step(1'b1, 1'b1, 1'b1, 5, -3);
    check("t5 relock locked", 32'(locked), 32'd0);
    check("t5 relock cnt", 32'(frame_cnt), 32'd2);
    check("t5 relock eras", 32'(frame_erasures), 32'd7);
    pilots(5);
    for (int k = 0; k < FS; k++) sym(-5, 3);
    check("t5 fresh frame", frame_data, 32'h5555_5555);
    check("t5 cnt", 32'(frame_cnt), 32'd3);
    step(1'b0, 1'b1, 1'b0, 4, -4);
    check("t5 reset data", frame_data, 32'd0);
    check("t5 reset cnt", 32'(frame_cnt), 32'd0);
    check("t5 reset locked", 32'(locked), 32'd0);

    pilots(5);
    p0 = pulses;
    for (int k = 0; k < 256 * FS; k++)
      sym(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
    idle();
    check("t6 cnt wrap", 32'(frame_cnt), 32'd0);
    check("t6 pulses", 32'(pulses - p0), 32'd256);

    step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      if (!m_locked && ($urandom % 4 != 0)) begin
        ri = int'($urandom_range(0, 7));
        rq = -int'($urandom_range(1, 8));
      end else begin
        ri = int'($urandom_range(0, 15)) - 8;
        rq = int'($urandom_range(0, 15)) - 8;
      end
      step(($urandom % 1000) != 0, ($urandom % 4) != 0, ($urandom % 300) == 0, ri, rq);
    end
    idle();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
